// File: rtl/reg_bank_arbiter.sv
// Round-robin shared register bank: one requester at a time gets a
// read / load / clear / preset on a single bank register, with a one-cycle ack.
module reg_bank_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic                    clk,
    input  logic                    synch_reset,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       cmd,
    input  logic [AW*NREQ-1:0]      addr,
    input  logic [WIDTH*NREQ-1:0]   wdata,
    input  logic                    clear_all,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    busy
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] CMD_READ   = 2'b00;
    localparam logic [1:0] CMD_LOAD   = 2'b01;
    localparam logic [1:0] CMD_CLEAR  = 2'b10;
    localparam logic [1:0] CMD_PRESET = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [IW-1:0]      last;
    logic [IW-1:0]      cur_idx;
    logic [1:0]         cur_cmd;
    logic [AW-1:0]      cur_addr;
    logic [WIDTH-1:0]   cur_wdata;
    logic [WIDTH-1:0]   bank [DEPTH];

    logic [1:0]         cmd_a   [NREQ];
    logic [AW-1:0]      addr_a  [NREQ];
    logic [WIDTH-1:0]   wdata_a [NREQ];

    logic               found;
    logic [IW-1:0]      win;
    logic [IW-1:0]      scan;
    logic [WIDTH-1:0]   exec_val;

    // Split the flat per-requester buses into indexable arrays
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign cmd_a[g]   = cmd[2*g +: 2];
        assign addr_a[g]  = addr[AW*g +: AW];
        assign wdata_a[g] = wdata[WIDTH*g +: WIDTH];
    end

    // Round-robin pick: first requesting index scanning upward from last+1
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan = IW'((32'(last) + k) % NREQ);
            if (!found && req[scan]) begin
                found = 1'b1;
                win   = scan;
            end
        end
    end

    // Value the latched command leaves in its register (current value for READ)
    always_comb begin
        exec_val = bank[cur_addr];
        case (cur_cmd)
            CMD_LOAD:   exec_val = cur_wdata;
            CMD_CLEAR:  exec_val = '0;
            CMD_PRESET: exec_val = '1;
            default:    exec_val = bank[cur_addr];
        endcase
    end

    // Bank storage; bulk clear beats any write issued in the same cycle
    always_ff @(posedge clk) begin
        if (synch_reset || clear_all) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (state == EXEC && cur_cmd != CMD_READ) begin
            bank[cur_addr] <= exec_val;
        end
    end

    // Control FSM: IDLE latches the winner, EXEC performs, DONE acks
    always_ff @(posedge clk) begin
        if (synch_reset) begin
            state     <= IDLE;
            grant     <= '0;
            ack       <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            last      <= IW'(NREQ - 1);
            cur_idx   <= '0;
            cur_cmd   <= CMD_READ;
            cur_addr  <= '0;
            cur_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (found) begin
                        cur_idx   <= win;
                        cur_cmd   <= cmd_a[win];
                        cur_addr  <= addr_a[win];
                        cur_wdata <= wdata_a[win];
                        grant     <= NREQ'(1) << win;
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end else begin
                        grant <= '0;
                    end
                end
                EXEC: begin
                    rd_data <= exec_val;
                    ack     <= grant;
                    state   <= DONE;
                end
                DONE: begin
                    ack   <= '0;
                    grant <= '0;
                    last  <= cur_idx;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack   <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter (NREQ=4, WIDTH=8, AW=3).
module tb_reg_bank_arbiter;

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] LD = 2'b01;
    localparam logic [1:0] CL = 2'b10;
    localparam logic [1:0] PR = 2'b11;

    logic        clk;
    logic        synch_reset;
    logic [3:0]  req;
    logic [7:0]  cmd;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        clear_all;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  rd_data;
    logic        busy;

    int tests;
    int fails;
    int cyc;

    logic [7:0] mb [8];
    int         model_last;

    typedef struct {
        int         r;
        logic [1:0] c;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;

    vec_t tbl [8];

    reg_bank_arbiter #(.NREQ(4), .WIDTH(8), .AW(3)) dut (
        .clk         (clk),
        .synch_reset (synch_reset),
        .req         (req),
        .cmd         (cmd),
        .addr        (addr),
        .wdata       (wdata),
        .clear_all   (clear_all),
        .grant       (grant),
        .ack         (ack),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int r, input logic [1:0] c, input logic [2:0] a, input logic [7:0] d);
        cmd[2*r +: 2]   = c;
        addr[3*r +: 3]  = a;
        wdata[8*r +: 8] = d;
        req[r]          = 1'b1;
    endtask

    // Bank contents the spec says a command leaves behind
    function automatic logic [7:0] model_result(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d);
        case (c)
            LD:      return d;
            CL:      return 8'h00;
            PR:      return 8'hFF;
            default: return mb[a];
        endcase
    endfunction

    // Round-robin rule: nearest pending requester strictly after the last winner
    function automatic int pick(input logic [3:0] pend, input int last_w);
        for (int k = 1; k <= 4; k++) begin
            if (pend[(last_w + k) % 4]) return (last_w + k) % 4;
        end
        return -1;
    endfunction

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (ack != 4'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack timeout", 32'(ack), 32'hFFFF_FFFF);
    endtask

    task automatic do_reset;
        synch_reset = 1'b1;
        req = '0;
        clear_all = 1'b0;
        tick();
        tick();
        synch_reset = 1'b0;
        for (int i = 0; i < 8; i++) mb[i] = 8'h00;
        model_last = 3;
    endtask

    // Single isolated operation with cycle-exact timing checks
    task automatic op(input int r, input logic [1:0] c, input logic [2:0] a,
                      input logic [7:0] d, input logic [7:0] e, input string nm);
        set_req(r, c, a, d);
        tick();
        check($sformatf("%s grant", nm), 32'(grant), 32'(1 << r));
        check($sformatf("%s busy", nm), 32'(busy), 32'd1);
        check($sformatf("%s early ack", nm), 32'(ack), 32'd0);
        tick();
        check($sformatf("%s ack", nm), 32'(ack), 32'(1 << r));
        check($sformatf("%s rd_data", nm), 32'(rd_data), 32'(e));
        req[r] = 1'b0;
        tick();
        check($sformatf("%s ack width", nm), 32'(ack), 32'd0);
        check($sformatf("%s grant clear", nm), 32'(grant), 32'd0);
        check($sformatf("%s idle", nm), 32'(busy), 32'd0);
        if (c != RD) mb[a] = model_result(c, a, d);
        model_last = r;
    endtask

    initial begin
        bit         got;
        int         prev;
        int         w;
        logic [3:0] pend;
        logic [1:0] rc [4];
        logic [2:0] ra [4];
        logic [7:0] rdv [4];
        logic [7:0] e;

        tests = 0;
        fails = 0;
        cyc = 0;
        req = '0;
        cmd = '0;
        addr = '0;
        wdata = '0;
        clear_all = 1'b0;
        synch_reset = 1'b1;

        tbl[0] = '{r: 0, c: LD, a: 3'd5, d: 8'hA5, e: 8'hA5};
        tbl[1] = '{r: 2, c: RD, a: 3'd5, d: 8'h00, e: 8'hA5};
        tbl[2] = '{r: 1, c: PR, a: 3'd2, d: 8'h00, e: 8'hFF};
        tbl[3] = '{r: 3, c: CL, a: 3'd2, d: 8'h00, e: 8'h00};
        tbl[4] = '{r: 0, c: RD, a: 3'd2, d: 8'h00, e: 8'h00};
        tbl[5] = '{r: 1, c: LD, a: 3'd0, d: 8'h12, e: 8'h12};
        tbl[6] = '{r: 3, c: RD, a: 3'd0, d: 8'h00, e: 8'h12};
        tbl[7] = '{r: 2, c: RD, a: 3'd5, d: 8'h00, e: 8'hA5};

        // Reset state
        do_reset();
        check("reset grant", 32'(grant), 32'd0);
        check("reset ack", 32'(ack), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        // Directed single operations
        for (int i = 0; i < 8; i++) begin
            op(tbl[i].r, tbl[i].c, tbl[i].a, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));
        end

        // All four requesting READ: order 0,1,2,3,0, acks 3 cycles apart
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, RD, 3'(i), 8'h00);
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_ack(got);
            check($sformatf("rr order %0d", n), 32'(ack), 32'(1 << (n % 4)));
            check($sformatf("rr grant %0d", n), 32'(grant), 32'(1 << (n % 4)));
            if (n > 0) check($sformatf("rr spacing %0d", n), 32'(cyc - prev), 32'd3);
            prev = cyc;
            if (n == 4) req = '0;
            tick();
            check($sformatf("rr ack width %0d", n), 32'(ack), 32'd0);
        end
        tick();
        model_last = 0;

        // clear_all during EXEC of a LOAD
        op(1, LD, 3'd3, 8'h77, 8'h77, "preload");
        set_req(0, LD, 3'd7, 8'h3C);
        tick();
        check("ca grant", 32'(grant), 32'd1);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        check("ca ack", 32'(ack), 32'd1);
        check("ca rd_data", 32'(rd_data), 32'h3C);
        req[0] = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) mb[i] = 8'h00;
        model_last = 0;
        for (int i = 0; i < 8; i++) begin
            op(2, RD, 3'(i), 8'h00, 8'h00, $sformatf("ca read%0d", i));
        end

        // Reset in the middle of EXEC drops the operation
        set_req(1, LD, 3'd1, 8'h55);
        tick();
        check("rst grant", 32'(grant), 32'd2);
        synch_reset = 1'b1;
        tick();
        synch_reset = 1'b0;
        req[1] = 1'b0;
        check("rst ack", 32'(ack), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst grant clr", 32'(grant), 32'd0);
        tick();
        check("rst no late ack", 32'(ack), 32'd0);
        for (int i = 0; i < 8; i++) mb[i] = 8'h00;
        model_last = 3;
        set_req(0, RD, 3'd1, 8'h00);
        set_req(3, RD, 3'd1, 8'h00);
        wait_ack(got);
        check("rst prio first", 32'(ack), 32'd1);
        check("rst read addr1", 32'(rd_data), 32'd0);
        req[0] = 1'b0;
        wait_ack(got);
        check("rst prio second", 32'(ack), 32'd8);
        req[3] = 1'b0;
        tick();
        tick();
        model_last = 3;

        // Requester 2 pulses req while 0 is served; it must be skipped
        set_req(0, RD, 3'd0, 8'h00);
        tick();
        check("drop grant0", 32'(grant), 32'd1);
        set_req(2, RD, 3'd4, 8'h00);
        tick();
        check("drop ack0", 32'(ack), 32'd1);
        req[2] = 1'b0;
        req[0] = 1'b0;
        tick();
        for (int n = 0; n < 4; n++) begin
            tick();
            check($sformatf("drop grant idle %0d", n), 32'(grant), 32'd0);
            check($sformatf("drop busy idle %0d", n), 32'(busy), 32'd0);
        end
        model_last = 0;

        // Randomized batches against the reference model
        for (int b = 0; b < 60; b++) begin
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                rc[i]  = 2'($urandom_range(0, 3));
                ra[i]  = 3'($urandom_range(0, 7));
                rdv[i] = 8'($urandom_range(0, 255));
                if (pend[i]) set_req(i, rc[i], ra[i], rdv[i]);
            end
            while (pend != 4'b0) begin
                wait_ack(got);
                if (!got) break;
                w = pick(pend, model_last);
                e = model_result(rc[w], ra[w], rdv[w]);
                check($sformatf("rnd%0d winner", b), 32'(ack), 32'(1 << w));
                check($sformatf("rnd%0d ack in grant", b), 32'(ack & ~grant), 32'd0);
                check($sformatf("rnd%0d rd_data", b), 32'(rd_data), 32'(e));
                if (rc[w] != RD) mb[ra[w]] = e;
                req[w] = 1'b0;
                pend[w] = 1'b0;
                model_last = w;
            end
            if ($urandom_range(0, 7) == 0) begin
                clear_all = 1'b1;
                tick();
                clear_all = 1'b0;
                for (int i = 0; i < 8; i++) mb[i] = 8'h00;
            end
        end
        req = '0;
        tick();
        tick();
        tick();
        check("final busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
